// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef enum logic {
    IFU_RUN   = 1'b0,
    IFU_FLUSH = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// In-order buffer of fetched {pc, inst} pairs; flush overrides push and
// discards everything, including an entry popped in the same cycle.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [ADDR_W-1:0]            push_pc,
  input  logic [INST_W-1:0]            push_inst,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [ADDR_W-1:0]            head_pc,
  output logic [INST_W-1:0]            head_inst
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // NOTE: storage is deliberately not reset; the head is masked to zero while
  // empty, so stale contents are never visible and the array stays plain RAM.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= '{pc: push_pc, inst: push_inst};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_pc   = (count != '0) ? mem[rd_ptr].pc   : '0;
  assign head_inst = (count != '0) ? mem[rd_ptr].inst : '0;

endmodule

// File: rtl/ifu_prefetch.sv
// Sequential-prefetch fetch unit: up to DEPTH fetches in flight or buffered,
// in-order delivery tagged with PC, redirect flushes and drops stale responses.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        io_reqValid,
  input  logic        io_reqReady,
  output logic [31:0] io_addr,
  input  logic        io_respValid,
  input  logic [31:0] io_rdata
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] count;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_cnt_nxt;
  ifu_state_e    state;

  logic credit_ok;
  logic req_fire;
  logic resp_ok;
  logic push;
  logic pop;

  // Credits cover both buffered and in-flight fetches, so a push can never overflow.
  assign credit_ok   = ({1'b0, inflight} + {1'b0, count}) < (CW+1)'(DEPTH);
  assign io_reqValid = !reset && fetch_en && !redirect_valid && credit_ok;
  assign io_addr     = io_reqValid ? fetch_pc : '0;
  assign req_fire    = io_reqValid && io_reqReady;
  assign resp_ok     = io_respValid && (inflight != '0);
  assign push        = resp_ok && (state == IFU_RUN) && !redirect_valid;
  assign respValid   = (count != '0);
  assign pop         = respValid && respReady;

  // NOTE: every variable gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    drop_cnt_nxt = drop_cnt;
    if (redirect_valid)
      drop_cnt_nxt = inflight - CW'(resp_ok);
    else if (resp_ok && (state == IFU_FLUSH))
      drop_cnt_nxt = drop_cnt - 1'b1;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      state    <= IFU_RUN;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(resp_ok);
      drop_cnt <= drop_cnt_nxt;
      state    <= (drop_cnt_nxt != '0) ? IFU_FLUSH : IFU_RUN;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push)     resp_pc  <= resp_pc + 32'd4;
      end
    end
  end

  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_pc   (resp_pc),
    .push_inst (io_rdata),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head_pc   (inst_pc),
    .head_inst (inst)
  );

  // Readable state name for waveform viewing.
  logic [8*5-1:0] state_name_unused;
  always_comb state_name_unused = (state == IFU_FLUSH) ? "FLUSH" : "RUN  ";

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset)
      assert (!(io_respValid && (inflight == '0)))
        else $error("ifu_prefetch: memory response with nothing in flight");
  end
`endif

endmodule
